// File: rtl/pc_fetch_ctrl.sv
// Purpose : program counter and fetch sequencer (IDLE -> RUN -> DONE) between
//           the branch unit and the instruction ROM.
// Latency : one cycle from start/branch/increment to the new value on pc;
//           fetch_en is running gated by the current stall.
// Backpressure: stall holds pc and state for the cycle. Branch and halt are
//           ignored while stall is high.
//
// Optional feature: define PCF_STATS_EN to add the cycle_count and
// branch_count outputs (16-bit, saturating, cleared on reset and on start).
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           one-cycle pulse: begin running at start_addr
//   start_addr      first instruction address
//   stall           hold pc this cycle
//   halt            current instruction is HALT
//   branch          branch taken for current instruction
//   address         branch target
//   pc              instruction ROM read address
//   fetch_en        ROM read enable (running & ~stall)
//   running, done   decoded state; done is sticky until the next start
//   overrun         pc ran off the end of program memory; sticky until start
//   cycle_count     (PCF_STATS_EN) cycles spent in RUN, stalls included
//   branch_count    (PCF_STATS_EN) accepted taken branches
module pc_fetch_ctrl #(
  parameter int PC_W       = 10,
  parameter int PROG_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch,
  input  logic [PC_W-1:0] address,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            running,
  output logic            done,
`ifdef PCF_STATS_EN
  output logic [15:0]     cycle_count,
  output logic [15:0]     branch_count,
`endif
  output logic            overrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(PROG_DEPTH - 1);

  logic [1:0] state;

  // An instruction is acted on only in RUN and not stalled.
  logic advance;
  assign advance = (state == ST_RUN) && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= '0;
      overrun <= 1'b0;
    end else if (start) begin
      state   <= ST_RUN;
      pc      <= start_addr;
      overrun <= 1'b0;
    end else if (advance) begin
      if (halt) begin
        // pc stays on the HALT instruction
        state <= ST_DONE;
      end else if (branch) begin
        pc <= address;
      end else if (pc == LAST_ADDR) begin
        // Falling off the end of program memory: stop and flag it.
        pc      <= '0;
        overrun <= 1'b1;
        state   <= ST_DONE;
      end else begin
        pc <= pc + PC_W'(1);
      end
    end
  end

  assign running  = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign fetch_en = running && !stall;

`ifdef PCF_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      cycle_count  <= 16'd0;
      branch_count <= 16'd0;
    end else if (state == ST_RUN) begin
      if (cycle_count != 16'hFFFF) begin
        cycle_count <= cycle_count + 16'd1;
      end
      if (!stall && !halt && branch && (branch_count != 16'hFFFF)) begin
        branch_count <= branch_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Purpose : directed table-driven bench for pc_fetch_ctrl plus a few
//           multi-cycle sequences (full run to wrap, counter saturation).
// Latency : each table row is one clock edge; outputs are checked 1 ns after it.
// Backpressure: stall is driven directly from the table rows.
module tb_pc_fetch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] start_addr;
  logic       stall;
  logic       halt;
  logic       branch;
  logic [9:0] address;
  logic [9:0] pc;
  logic       fetch_en;
  logic       running;
  logic       done;
  logic       overrun;
`ifdef PCF_STATS_EN
  logic [15:0] cycle_count;
  logic [15:0] branch_count;
`endif

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl #(.PC_W(10), .PROG_DEPTH(1024)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .stall       (stall),
    .halt        (halt),
    .branch      (branch),
    .address     (address),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .running     (running),
    .done        (done),
`ifdef PCF_STATS_EN
    .cycle_count (cycle_count),
    .branch_count(branch_count),
`endif
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rn;
    logic       st;
    logic [9:0] sa;
    logic       sl;
    logic       h;
    logic       b;
    logic [9:0] a;
    logic [9:0] epc;
    logic       er;
    logic       ed;
    logic       eo;
    int         ec;
    int         eb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rn, input logic st, input logic [9:0] sa,
                              input logic sl, input logic h, input logic b,
                              input logic [9:0] a, input logic [9:0] epc,
                              input logic er, input logic ed, input logic eo,
                              input int ec, input int eb);
    vec_t v;
    v.rn = rn; v.st = st; v.sa = sa; v.sl = sl; v.h = h; v.b = b; v.a = a;
    v.epc = epc; v.er = er; v.ed = ed; v.eo = eo; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic st, input logic [9:0] sa,
                       input logic sl, input logic h, input logic b,
                       input logic [9:0] a);
    @(negedge clk);
    rst_n = rn; start = st; start_addr = sa; stall = sl;
    halt = h; branch = b; address = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0;
    halt = 1'b0; branch = 1'b0; address = '0;

    //      rn st sa      sl h b a        epc   er ed eo ec eb
    // reset with start held high: start must be ignored
    vq.push_back(mk(0, 1, 10'd77,  0, 0, 0, 10'd0,   10'd0,    0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 10'd77,  0, 0, 0, 10'd0,   10'd0,    0, 0, 0, 0, 0));
    // IDLE ignores branch/halt/stall
    vq.push_back(mk(1, 0, 10'd0,   0, 1, 1, 10'h055, 10'd0,    0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   1, 0, 1, 10'h055, 10'd0,    0, 0, 0, 0, 0));
    // straight-line run from 5
    vq.push_back(mk(1, 1, 10'd5,   0, 0, 0, 10'd0,   10'd5,    1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd6,    1, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd7,    1, 0, 0, 2, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd8,    1, 0, 0, 3, 0));
    // branch at pc=8, then halt, then DONE ignores branch and stall
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 1, 10'h040, 10'd64,   1, 0, 0, 4, 1));
    vq.push_back(mk(1, 0, 10'd0,   0, 1, 0, 10'd0,   10'd64,   0, 1, 0, 5, 1));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 1, 10'h123, 10'd64,   0, 1, 0, 5, 1));
    vq.push_back(mk(1, 0, 10'd0,   1, 0, 0, 10'd0,   10'd64,   0, 1, 0, 5, 1));
    // stall beats branch; halt beats branch
    vq.push_back(mk(1, 1, 10'd18,  0, 0, 0, 10'd0,   10'd18,   1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd19,   1, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd20,   1, 0, 0, 2, 0));
    vq.push_back(mk(1, 0, 10'd0,   1, 0, 1, 10'h100, 10'd20,   1, 0, 0, 3, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 1, 1, 10'h100, 10'd20,   0, 1, 0, 4, 0));
    // stall beats halt
    vq.push_back(mk(1, 1, 10'd40,  0, 0, 0, 10'd0,   10'd40,   1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   1, 1, 0, 10'd0,   10'd40,   1, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd41,   1, 0, 0, 2, 0));
    // wrap and overrun, sticky in DONE, cleared by start
    vq.push_back(mk(1, 1, 10'h3FE, 0, 0, 0, 10'd0,   10'd1022, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd1023, 1, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd0,    0, 1, 1, 2, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd0,    0, 1, 1, 2, 0));
    vq.push_back(mk(1, 1, 10'd0,   0, 0, 0, 10'd0,   10'd0,    1, 0, 0, 0, 0));
    // branch or halt at the last address do not set overrun
    vq.push_back(mk(1, 1, 10'h3FF, 0, 0, 0, 10'd0,   10'd1023, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 1, 10'd3,   10'd3,    1, 0, 0, 1, 1));
    vq.push_back(mk(1, 1, 10'h3FF, 0, 0, 0, 10'd0,   10'd1023, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 1, 0, 10'd0,   10'd1023, 0, 1, 0, 1, 0));
    // reset mid-run at pc=30
    vq.push_back(mk(1, 1, 10'd28,  0, 0, 0, 10'd0,   10'd28,   1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd29,   1, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd30,   1, 0, 0, 2, 0));
    vq.push_back(mk(0, 0, 10'd0,   0, 0, 0, 10'd0,   10'd0,    0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd0,    0, 0, 0, 0, 0));
    // restart during RUN clears counters; start beats stall/halt/branch
    vq.push_back(mk(1, 1, 10'd100, 0, 0, 0, 10'd0,   10'd100,  1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 1, 10'd150, 10'd150,  1, 0, 0, 1, 1));
    vq.push_back(mk(1, 1, 10'd200, 0, 0, 0, 10'd0,   10'd200,  1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 10'd0,   0, 0, 0, 10'd0,   10'd201,  1, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, 10'd300, 1, 1, 1, 10'd7,   10'd300,  1, 0, 0, 0, 0));

    foreach (vq[i]) begin
      drive(vq[i].rn, vq[i].st, vq[i].sa, vq[i].sl, vq[i].h, vq[i].b, vq[i].a);
      chk("pc",       i, 32'(pc),       32'(vq[i].epc));
      chk("running",  i, 32'(running),  32'(vq[i].er));
      chk("done",     i, 32'(done),     32'(vq[i].ed));
      chk("overrun",  i, 32'(overrun),  32'(vq[i].eo));
      chk("fetch_en", i, 32'(fetch_en), 32'(vq[i].er & ~vq[i].sl));
`ifdef PCF_STATS_EN
      chk("cycle_count",  i, 32'(cycle_count),  32'(vq[i].ec));
      chk("branch_count", i, 32'(branch_count), 32'(vq[i].eb));
`endif
    end

    // Free run from 0x3F0 until done: 15 increments then the wrap edge.
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      drive(1, 1, 10'h3F0, 0, 0, 0, 10'd0);
      for (int k = 0; k < 40 && !seen; k++) begin
        drive(1, 0, 10'd0, 0, 0, 0, 10'd0);
        n++;
        if (done) seen = 1'b1;
      end
      chk("wrap_seen",    100, 32'(seen),    32'd1);
      chk("wrap_edges",   100, 32'(n),       32'd16);
      chk("wrap_pc",      100, 32'(pc),      32'd0);
      chk("wrap_overrun", 100, 32'(overrun), 32'd1);
    end

    // Several idle cycles after reset: pc stays at 0, nothing runs.
    drive(0, 0, 10'd0, 0, 0, 0, 10'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 10'd0, 0, 0, 1, 10'd9);
      chk("idle_pc",      101 + k, 32'(pc),       32'd0);
      chk("idle_fetchen", 101 + k, 32'(fetch_en), 32'd0);
    end

`ifdef PCF_STATS_EN
    // Cycle counter saturates while stalled in RUN.
    drive(1, 1, 10'd12, 0, 0, 0, 10'd0);
    for (int k = 0; k < 65540; k++) begin
      drive(1, 0, 10'd0, 1, 0, 1, 10'd3);
    end
    chk("sat_cycle",  200, 32'(cycle_count),  32'h0000FFFF);
    chk("sat_branch", 200, 32'(branch_count), 32'd0);
    chk("sat_pc",     200, 32'(pc),           32'd12);
    chk("sat_run",    200, 32'(running),      32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
